// File: rtl/mod_counter_hex_if.sv
// mod_counter_hex_if
//   Groups the control inputs and display/status outputs of the
//   modulo-N HEX counter so the board top can hand one bundle around.
//   master : board side (drives enable/up_down/load/load_value,
//            observes count/tc/overflow/hex_out)
//   slave  : counter side (the reverse)
//   WIDTH must match the counter's WIDTH parameter; hex_out carries
//   7 active-low segment bits per 4-bit nibble of count.
interface mod_counter_hex_if #(
  parameter int WIDTH = 8
);
  logic                   enable;
  logic                   up_down;
  logic                   load;
  logic [WIDTH-1:0]       load_value;
  logic [WIDTH-1:0]       count;
  logic                   tc;
  logic                   overflow;
  logic [7*WIDTH/4-1:0]   hex_out;

  modport master (
    output enable, up_down, load, load_value,
    input  count, tc, overflow, hex_out
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output count, tc, overflow, hex_out
  );
endinterface

// File: rtl/mod_counter_hex.sv
// mod_counter_hex
//   Modulo-N up/down counter with prescaler, synchronous load (clamped to
//   the modulus), wrap or saturate at the boundary, a one-cycle terminal
//   count pulse, a sticky overflow flag and one active-low 7-segment digit
//   per nibble of the count.
// Ports
//   clock : rising-edge clock
//   clear : asynchronous reset, active-high
//   bus   : mod_counter_hex_if.slave
//           enable, up_down, load, load_value in;
//           count, tc, overflow, hex_out out
// Parameters
//   WIDTH (multiple of 4), MODULUS (2..2**WIDTH), DIV (>=1), SATURATE (0/1)
module mod_counter_hex #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int DIV      = 1,
  parameter int SATURATE = 0
) (
  input  logic              clock,
  input  logic              clear,
  mod_counter_hex_if.slave  bus
);

  localparam int NDIG = WIDTH / 4;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
  localparam logic [PW-1:0]    PRESC_TOP = PW'(DIV - 1);
  localparam bit               WRAP      = (SATURATE == 0);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tc_q, tc_d;
  logic              ovf_q, ovf_d;
  logic              tick;
  logic [WIDTH-1:0]  load_clamped;
  logic [7*NDIG-1:0] hex_w;

  // Prescaler is a down-counter reloaded with DIV-1; reaching zero while
  // enabled is the terminal count. Equivalent to an up-counter 0..DIV-1,
  // so the first tick after clear/load still lands DIV enabled edges later.
  assign tick = bus.enable && (presc_q == '0);

  assign load_clamped = ({1'b0, bus.load_value} >= MOD_EXT) ? MAX_COUNT
                                                            : bus.load_value;

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (bus.load) begin
      count_d = load_clamped;
      presc_d = PRESC_TOP;
      ovf_d   = 1'b0;
    end else if (tick) begin
      presc_d = PRESC_TOP;
      if (bus.up_down) begin
        if (count_q == MAX_COUNT) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (WRAP) count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (WRAP) count_d = MAX_COUNT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end else if (bus.enable) begin
      presc_d = presc_q - PW'(1);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
      presc_q <= PRESC_TOP;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Segment order bit0=a .. bit6=g, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    hex_w = '0;
    for (int d = 0; d < NDIG; d++) begin
      hex_w[7*d +: 7] = seg7(count_q[4*d +: 4]);
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.overflow = ovf_q;
  assign bus.hex_out  = hex_w;

endmodule
